// File: rtl/rotator_pipe_pkg.sv
// Shared definitions for the three-stage barrel rotator: default widths,
// direction encoding and the rotate-left helper used by every stage.
package rotator_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Rotate toward the MSB: the top half of {data,data} shifted left is the rotation.
  function automatic logic [DEF_WIDTH-1:0] rotl(input logic [DEF_WIDTH-1:0] data,
                                                input logic [DEF_AMT_W-1:0] amt);
    logic [2*DEF_WIDTH-1:0] dbl;
    dbl = {data, data} << amt;
    return dbl[2*DEF_WIDTH-1 -: DEF_WIDTH];
  endfunction

endpackage

// File: rtl/rotator_pipe_if.sv
// Operand/result handshake bundle for the rotator: valid/ready on the input
// side and on the output side, with the rotate controls carried alongside.
interface rotator_pipe_if #(
  parameter int WIDTH = rotator_pipe_pkg::DEF_WIDTH,
  parameter int AMT_W = rotator_pipe_pkg::DEF_AMT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_dir;
  logic [AMT_W-1:0] out_amt;

  // The operand source / result consumer side.
  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_dir, out_amt
  );

  // The rotator itself.
  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_dir, out_amt
  );

endinterface

// File: rtl/rotator_pipe_reverse.sv
// Bit-reverse stage: bit i of rev is bit WIDTH-1-i of data. Purely combinational.
module rotator_pipe_reverse #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rev
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign rev[i] = data[WIDTH-1-i];
  end

endmodule

// File: rtl/rotator_pipe.sv
// Three-stage pipelined barrel rotator. Right rotates are done as
// reverse -> rotate left -> reverse; each stage handles one amount bit.
module rotator_pipe
  import rotator_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input logic          clk,
  input logic          rst,
  rotator_pipe_if.slave bus
);

  logic             v1, v2, v3;
  logic [WIDTH-1:0] d1, d2, d3;
  logic [AMT_W-1:0] a1, a2, a3;
  logic             r1, r2, r3;
  logic             en1, en2, en3;

  logic [WIDTH-1:0] pre_rev, pre_d;
  logic [WIDTH-1:0] s3_rot, post_rev, post_d;

  // An empty stage always loads, so bubbles collapse even while the output is stalled.
  assign en3 = !v3 || bus.out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;
  assign bus.in_ready = en1;

  rotator_pipe_reverse #(.WIDTH(WIDTH)) u_pre_rev (
    .data (bus.in_data),
    .rev  (pre_rev)
  );
  assign pre_d = (bus.in_dir == DIR_RIGHT) ? pre_rev : bus.in_data;

  assign s3_rot = rotl(d2, a2 & AMT_W'(1));

  rotator_pipe_reverse #(.WIDTH(WIDTH)) u_post_rev (
    .data (s3_rot),
    .rev  (post_rev)
  );
  assign post_d = (r2 == DIR_RIGHT) ? post_rev : s3_rot;

  // NOTE: every register here uses <= so all stages sample the pre-edge values
  // of their upstream stage; blocking assignments would let an item skip a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data/amt/dir registers are reset too, because the result
      // port must read 0 while the pipe is empty after reset.
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      a1 <= '0;
      a2 <= '0;
      a3 <= '0;
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        // Payload only moves with a valid item, so idle X on in_data stays out.
        if (bus.in_valid) begin
          d1 <= rotl(pre_d, bus.in_amt & AMT_W'(4));
          a1 <= bus.in_amt;
          r1 <= bus.in_dir;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          d2 <= rotl(d1, a1 & AMT_W'(2));
          a2 <= a1;
          r2 <= r1;
        end
      end
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          d3 <= post_d;
          a3 <= a2;
          r3 <= r2;
        end
      end
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_data  = d3;
  assign bus.out_amt   = a3;
  assign bus.out_dir   = r3;

endmodule

// File: tb/tb_rotator_pipe.sv
// Self-checking bench for rotator_pipe: a queue-based reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_rotator_pipe;
  import rotator_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rotator_pipe_if bus ();

  rotator_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    int         cyc;
  } item_t;

  item_t      exp_q[$];
  logic [7:0] out_log[$];
  int         lat_log[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rotate from plain integer arithmetic.
  function automatic logic [7:0] sw_rot(input logic [7:0] d, input int a, input logic dir);
    int x, r;
    x = int'(d);
    if (dir == 1'b0) r = ((x << a) | (x >> (8 - a))) & 255;
    else             r = ((x >> a) | (x << (8 - a))) & 255;
    return 8'(r);
  endfunction

  // Compare process: sampled mid-cycle, ahead of the edge where transfers happen.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [2:0] prev_amt;
  logic       prev_dir;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_amt", bus.out_amt, prev_amt);
        check("stall_dir", bus.out_dir, prev_dir);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", bus.out_valid, 0);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("model_data", bus.out_data, sw_rot(e.data, int'(e.amt), e.dir));
          check("model_amt", bus.out_amt, e.amt);
          check("model_dir", bus.out_dir, e.dir);
          out_log.push_back(bus.out_data);
          lat_log.push_back(cyc - e.cyc);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{data: bus.in_data, amt: bus.in_amt, dir: bus.in_dir, cyc: cyc});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_amt   = bus.out_amt;
      prev_dir   = bus.out_dir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one item and hold it until accepted; waits = edges spent.
  task automatic push(input logic [7:0] d, input logic [2:0] a, input logic dir, output int waits);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = dir;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      logic acc;
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      waits++;
      if (acc) return;
    end
    check("push_accept", bus.in_ready, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_expect(input string name, input logic [7:0] d, input logic [2:0] a,
                             input logic dir, input logic [7:0] exp);
    int w, lat;
    bus.out_ready = 1'b1;
    push(d, a, dir, w);
    idle();
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_data"}, bus.out_data, exp);
    tick();
    check({name, "_pulse"}, bus.out_valid, 0);
  endtask

  logic [7:0] bp_data[5] = '{8'h81, 8'h81, 8'h3C, 8'h0F, 8'hA5};
  logic [2:0] bp_amt[5]  = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd7};
  logic       bp_dir[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) tick();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_amt", bus.out_amt, 0);
    check("reset_out_dir", bus.out_dir, 0);
    rst = 1'b0;
    tick();
    check("reset_in_ready", bus.in_ready, 1);

    // Directed single items
    send_expect("left_83_a1", 8'h83, 3'd1, 1'b0, 8'h07);
    send_expect("right_83_a1", 8'h83, 3'd1, 1'b1, 8'hC1);
    send_expect("right_f0_a3", 8'hF0, 3'd3, 1'b1, 8'h1E);
    send_expect("left_d4_a4", 8'hD4, 3'd4, 1'b0, 8'h4D);
    send_expect("right_d4_a4", 8'hD4, 3'd4, 1'b1, 8'h4D);
    send_expect("right_5a_a0", 8'h5A, 3'd0, 1'b1, 8'h5A);
    send_expect("left_5a_a0", 8'h5A, 3'd0, 1'b0, 8'h5A);

    // Back-to-back streaming of every (amt, dir) pair on 0x80
    out_log.delete();
    lat_log.delete();
    for (int dir = 0; dir < 2; dir++)
      for (int a = 0; a < 8; a++) begin
        push(8'h80, 3'(a), 1'(dir), w);
        check("stream_accept", w, 1);
      end
    idle();
    drain();
    check("stream_count", out_log.size(), 16);
    if (out_log.size() == 16) begin
      check("stream_l1", out_log[1], 8'h01);
      check("stream_l4", out_log[4], 8'h08);
      check("stream_r1", out_log[9], 8'h40);
      check("stream_r7", out_log[15], 8'h01);
    end
    foreach (lat_log[i]) check("stream_latency", lat_log[i], 3);

    // Backpressure: only three items fit while the output is stalled
    out_log.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(bp_data[i], bp_amt[i], bp_dir[i], w);
      check("bp_fill_accept", w, 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = bp_data[3];
    bus.in_amt   = bp_amt[3];
    bus.in_dir   = bp_dir[3];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data_first", bus.out_data, 8'h03);
      tick();
    end
    bus.out_ready = 1'b1;
    push(bp_data[3], bp_amt[3], bp_dir[3], w);
    push(bp_data[4], bp_amt[4], bp_dir[4], w);
    idle();
    drain();
    check("bp_count", out_log.size(), 5);
    if (out_log.size() == 5) begin
      check("bp_first", out_log[0], 8'h03);
      check("bp_second", out_log[1], 8'hC0);
      check("bp_fourth", out_log[3], 8'h78);
      check("bp_last", out_log[4], 8'hD2);
    end

    // Idle X on the operand must not create a valid result
    bus.in_data = 'x;
    bus.in_amt  = 'x;
    bus.in_dir  = 1'bx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_x_out_valid", bus.out_valid, 0);
      tick();
    end

    // Reset with two items in flight and the head stalled at the output
    bus.out_ready = 1'b0;
    push(8'h11, 3'd1, 1'b0, w);
    push(8'h22, 3'd2, 1'b0, w);
    idle();
    tick();
    check("pre_reset_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_out_valid", bus.out_valid, 0);
    check("mid_reset_out_data", bus.out_data, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);
    send_expect("post_reset", 8'h83, 3'd1, 1'b1, 8'hC1);

    // Full pipe with transfers on both sides every cycle
    out_log.delete();
    lat_log.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(8'(i * 17 + 3), 3'(i % 8), 1'(i % 2), w);
      check("full_in_ready", w, 1);
    end
    idle();
    drain();
    check("full_count", out_log.size(), 10);
    if (out_log.size() == 10) begin
      check("full_item0", out_log[0], 8'h03);
      check("full_item1", out_log[1], 8'h0A);
    end
    foreach (lat_log[i]) check("full_latency", lat_log[i], 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
